// File: rtl/jala_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jala_ctrl_pkg
//  Description : Shared encodings for the JALA stack CPU control unit:
//                state enum, opcode constants, datapath select encodings
//                and a small opcode classification helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package jala_ctrl_pkg;

   // Control FSM states (4-bit, also exported on StateOut for debug)
   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_POPA   = 4'd2,
      S_POPB   = 4'd3,
      S_EXEC   = 4'd4,
      S_INCSP  = 4'd5,
      S_WRITE  = 4'd6,
      S_JUMP   = 4'd7,
      S_BRANCH = 4'd8,
      S_RPUSH  = 4'd9,
      S_RWRITE = 4'd10,
      S_RPOP   = 4'd11,
      S_JUMPA  = 4'd12,
      S_HALT   = 4'd13
   } state_e;

   // Opcodes (IR[15:12]); 4'hA..4'hE are illegal and behave as HALT
   localparam logic [3:0] OP_ADD   = 4'h0;
   localparam logic [3:0] OP_SUB   = 4'h1;
   localparam logic [3:0] OP_AND   = 4'h2;
   localparam logic [3:0] OP_OR    = 4'h3;
   localparam logic [3:0] OP_PUSHI = 4'h4;
   localparam logic [3:0] OP_POP   = 4'h5;
   localparam logic [3:0] OP_JREL  = 4'h6;
   localparam logic [3:0] OP_BEQZ  = 4'h7;
   localparam logic [3:0] OP_CALL  = 4'h8;
   localparam logic [3:0] OP_RET   = 4'h9;
   localparam logic [3:0] OP_HALT  = 4'hF;

   // Memory port 1 address select
   localparam logic [1:0] MEMDST1_PC  = 2'd0;
   localparam logic [1:0] MEMDST1_MSP = 2'd1;

   // Memory port 2 address select
   localparam logic [1:0] MEMDST2_MSP = 2'd0;
   localparam logic [1:0] MEMDST2_RSP = 2'd1;

   // Memory write-data select
   localparam logic [2:0] MEMDATA_PC    = 3'd0;
   localparam logic [2:0] MEMDATA_RES   = 3'd1;
   localparam logic [2:0] MEMDATA_ZEIMM = 3'd2;

   // ALU operation encodings (equal to the low opcode bits of ALU ops)
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_OR  = 2'd3;

   // ALU opcodes occupy 0..3
   function automatic logic is_alu_op(input logic [3:0] op);
      return (op[3:2] == 2'b00);
   endfunction

endpackage : jala_ctrl_pkg
`default_nettype wire

// File: rtl/stack_ctrl_outputs.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ctrl_outputs
//  Description : Moore output decode for the JALA control FSM. Maps the
//                current state and latched opcode to every datapath
//                control. Reset blanks all outputs; Stall blanks only the
//                strobes while selects keep their values.
//  Ports       : rst_n_i    - async active-low reset level (blanks outputs)
//                state_i    - current FSM state
//                opcode_i   - latched opcode
//                zero_i     - datapath zero flag (BRANCH condition)
//                stall_i    - memory-side hold request
//                *_o        - datapath strobes and selects
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_ctrl_outputs
   import jala_ctrl_pkg::*;
(
   input  logic       rst_n_i,
   input  state_e     state_i,
   input  logic [3:0] opcode_i,
   input  logic       zero_i,
   input  logic       stall_i,
   output logic       msp_write_o,
   output logic       msp_pop_o,
   output logic       rsp_write_o,
   output logic       rsp_pop_o,
   output logic       pc_write_o,
   output logic       pc_source_o,
   output logic       pc_add_o,
   output logic       vala_write_o,
   output logic       valb_write_o,
   output logic       ir_write_o,
   output logic       mem_read1_o,
   output logic       mem_read2_o,
   output logic       mem_write1_o,
   output logic       mem_write2_o,
   output logic [1:0] mem_dst1_o,
   output logic [1:0] mem_dst2_o,
   output logic [2:0] mem_data_o,
   output logic [1:0] alu_op_o,
   output logic       res_write_o,
   output logic       halted_o
);

   always_comb begin
      msp_write_o  = 1'b0;
      msp_pop_o    = 1'b0;
      rsp_write_o  = 1'b0;
      rsp_pop_o    = 1'b0;
      pc_write_o   = 1'b0;
      pc_source_o  = 1'b0;
      pc_add_o     = 1'b0;
      vala_write_o = 1'b0;
      valb_write_o = 1'b0;
      ir_write_o   = 1'b0;
      mem_read1_o  = 1'b0;
      mem_read2_o  = 1'b0;
      mem_write1_o = 1'b0;
      mem_write2_o = 1'b0;
      mem_dst1_o   = MEMDST1_PC;
      mem_dst2_o   = MEMDST2_MSP;
      mem_data_o   = MEMDATA_PC;
      alu_op_o     = ALU_ADD;
      res_write_o  = 1'b0;
      halted_o     = 1'b0;

      // The state register already reads FETCH during reset; gating here
      // keeps FETCH strobes from firing until reset is released.
      if (rst_n_i) begin
         unique case (state_i)
            S_FETCH: begin
               mem_read1_o = 1'b1;
               mem_dst1_o  = MEMDST1_PC;
               ir_write_o  = 1'b1;
               pc_write_o  = 1'b1;
            end
            S_POPA: begin
               mem_read2_o  = 1'b1;
               vala_write_o = 1'b1;
               msp_write_o  = 1'b1;
               msp_pop_o    = 1'b1;
            end
            S_POPB: begin
               mem_read2_o  = 1'b1;
               valb_write_o = 1'b1;
               msp_write_o  = 1'b1;
               msp_pop_o    = 1'b1;
            end
            S_EXEC: begin
               res_write_o = 1'b1;
               alu_op_o    = opcode_i[1:0];
            end
            S_INCSP: begin
               msp_write_o = 1'b1;
            end
            S_WRITE: begin
               mem_write2_o = 1'b1;
               mem_data_o   = (opcode_i == OP_PUSHI) ? MEMDATA_ZEIMM : MEMDATA_RES;
            end
            S_JUMP: begin
               pc_write_o = 1'b1;
               pc_add_o   = 1'b1;
            end
            S_BRANCH: begin
               pc_write_o = zero_i;
               pc_add_o   = 1'b1;
            end
            S_RPUSH: begin
               rsp_write_o = 1'b1;
            end
            S_RWRITE: begin
               mem_write2_o = 1'b1;
               mem_dst2_o   = MEMDST2_RSP;
               mem_data_o   = MEMDATA_PC;
            end
            S_RPOP: begin
               mem_read2_o  = 1'b1;
               mem_dst2_o   = MEMDST2_RSP;
               vala_write_o = 1'b1;
               rsp_write_o  = 1'b1;
               rsp_pop_o    = 1'b1;
            end
            S_JUMPA: begin
               pc_write_o  = 1'b1;
               pc_source_o = 1'b1;
            end
            S_HALT: begin
               halted_o = 1'b1;
            end
            default: begin
               // S_DECODE and unused encodings drive nothing
            end
         endcase

         // Stall suppresses side effects but leaves selects stable
         if (stall_i) begin
            msp_write_o  = 1'b0;
            rsp_write_o  = 1'b0;
            pc_write_o   = 1'b0;
            vala_write_o = 1'b0;
            valb_write_o = 1'b0;
            ir_write_o   = 1'b0;
            mem_read1_o  = 1'b0;
            mem_read2_o  = 1'b0;
            mem_write1_o = 1'b0;
            mem_write2_o = 1'b0;
            res_write_o  = 1'b0;
         end
      end
   end

endmodule : stack_ctrl_outputs
`default_nettype wire

// File: rtl/stack_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : stack_control_fsm
//  Description : Multicycle control unit for the JALA stack CPU. Holds the
//                state and latched-opcode registers and the next-state
//                logic; output decode lives in stack_ctrl_outputs.
//  Ports       : CLK, RSTn (async active-low), Opcode (IR[15:12]), Zero,
//                Stall in; stack-pointer, PC, register-load, memory,
//                ALU strobes/selects, Halted and StateOut out.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_control_fsm
   import jala_ctrl_pkg::*;
(
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [3:0] Opcode,
   input  logic       Zero,
   input  logic       Stall,
   output logic       MSPWrite,
   output logic       MSPPop,
   output logic       RSPWrite,
   output logic       RSPPop,
   output logic       PCWrite,
   output logic       PCSource,
   output logic       PCAdd,
   output logic       ValAWrite,
   output logic       ValBWrite,
   output logic       IRWrite,
   output logic       MemRead1,
   output logic       MemRead2,
   output logic       MemWrite1,
   output logic       MemWrite2,
   output logic [1:0] MemDst1,
   output logic [1:0] MemDst2,
   output logic [2:0] MemData,
   output logic [1:0] ALUOp,
   output logic       ResWrite,
   output logic       Halted,
   output logic [3:0] StateOut
);

   state_e     state_q, state_d;
   logic [3:0] opcode_q, opcode_d;

   // State register
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q  <= S_FETCH;
         opcode_q <= 4'h0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   // Next-state logic. DECODE dispatches on the live Opcode since the
   // latched copy only becomes valid after that edge.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      unique case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            opcode_d = Opcode;
            unique case (Opcode)
               OP_ADD, OP_SUB, OP_AND, OP_OR,
               OP_POP, OP_BEQZ:             state_d = S_POPA;
               OP_PUSHI:                    state_d = S_INCSP;
               OP_JREL:                     state_d = S_JUMP;
               OP_CALL:                     state_d = S_RPUSH;
               OP_RET:                      state_d = S_RPOP;
               default:                     state_d = S_HALT;
            endcase
         end
         S_POPA: begin
            if (is_alu_op(opcode_q))       state_d = S_POPB;
            else if (opcode_q == OP_BEQZ)  state_d = S_BRANCH;
            else                           state_d = S_FETCH;
         end
         S_POPB:   state_d = S_EXEC;
         S_EXEC:   state_d = S_INCSP;
         S_INCSP:  state_d = S_WRITE;
         S_WRITE:  state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_RPUSH:  state_d = S_RWRITE;
         S_RWRITE: state_d = S_JUMP;
         S_RPOP:   state_d = S_JUMPA;
         S_JUMPA:  state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_HALT;
      endcase

      // Stall freezes both registers; the instruction resumes where it was
      if (Stall) begin
         state_d  = state_q;
         opcode_d = opcode_q;
      end
   end

   // Output decode
   stack_ctrl_outputs u_outputs (
      .rst_n_i      (RSTn),
      .state_i      (state_q),
      .opcode_i     (opcode_q),
      .zero_i       (Zero),
      .stall_i      (Stall),
      .msp_write_o  (MSPWrite),
      .msp_pop_o    (MSPPop),
      .rsp_write_o  (RSPWrite),
      .rsp_pop_o    (RSPPop),
      .pc_write_o   (PCWrite),
      .pc_source_o  (PCSource),
      .pc_add_o     (PCAdd),
      .vala_write_o (ValAWrite),
      .valb_write_o (ValBWrite),
      .ir_write_o   (IRWrite),
      .mem_read1_o  (MemRead1),
      .mem_read2_o  (MemRead2),
      .mem_write1_o (MemWrite1),
      .mem_write2_o (MemWrite2),
      .mem_dst1_o   (MemDst1),
      .mem_dst2_o   (MemDst2),
      .mem_data_o   (MemData),
      .alu_op_o     (ALUOp),
      .res_write_o  (ResWrite),
      .halted_o     (Halted)
   );

   assign StateOut = state_q;

endmodule : stack_control_fsm
`default_nettype wire

// File: tb/tb_stack_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_control_fsm
//  Description : Self-checking bench for stack_control_fsm. A table of
//                per-cycle {Opcode, Zero, Stall, expected outputs} rows walks
//                every instruction class back to back; HALT, reset pulse and
//                asynchronous mid-EXEC reset are driven by hand.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_control_fsm;

   logic       CLK = 1'b0;
   logic       RSTn;
   logic [3:0] Opcode;
   logic       Zero;
   logic       Stall;
   logic       MSPWrite, MSPPop, RSPWrite, RSPPop;
   logic       PCWrite, PCSource, PCAdd;
   logic       ValAWrite, ValBWrite, IRWrite;
   logic       MemRead1, MemRead2, MemWrite1, MemWrite2;
   logic [1:0] MemDst1, MemDst2;
   logic [2:0] MemData;
   logic [1:0] ALUOp;
   logic       ResWrite, Halted;
   logic [3:0] StateOut;

   stack_control_fsm dut (
      .CLK(CLK), .RSTn(RSTn), .Opcode(Opcode), .Zero(Zero), .Stall(Stall),
      .MSPWrite(MSPWrite), .MSPPop(MSPPop), .RSPWrite(RSPWrite), .RSPPop(RSPPop),
      .PCWrite(PCWrite), .PCSource(PCSource), .PCAdd(PCAdd),
      .ValAWrite(ValAWrite), .ValBWrite(ValBWrite), .IRWrite(IRWrite),
      .MemRead1(MemRead1), .MemRead2(MemRead2),
      .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
      .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
      .ALUOp(ALUOp), .ResWrite(ResWrite), .Halted(Halted), .StateOut(StateOut)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic       msp_write, msp_pop, rsp_write, rsp_pop;
      logic       pc_write, pc_source, pc_add;
      logic       vala_write, valb_write, ir_write;
      logic       mem_read1, mem_read2, mem_write1, mem_write2;
      logic [1:0] mem_dst1, mem_dst2;
      logic [2:0] mem_data;
      logic [1:0] alu_op;
      logic       res_write, halted;
      logic [3:0] state;
   } ctl_t;

   typedef struct {
      logic [3:0] op;
      logic       zero;
      logic       stall;
      ctl_t       exp;
   } vec_t;

   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;

   ctl_t act;
   assign act = {MSPWrite, MSPPop, RSPWrite, RSPPop, PCWrite, PCSource, PCAdd,
                 ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2,
                 MemWrite1, MemWrite2, MemDst1, MemDst2, MemData, ALUOp,
                 ResWrite, Halted, StateOut};

   function automatic ctl_t base(input logic [3:0] st);
      ctl_t c;
      c       = '0;
      c.state = st;
      return c;
   endfunction

   task automatic add(input logic [3:0] op, input logic z, input logic s, input ctl_t e);
      vec_t v;
      v.op = op; v.zero = z; v.stall = s; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input ctl_t e);
      total++;
      if (act !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h (state got %0d want %0d)",
                  name, act, e, act.state, e.state);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Hand-computed expected output sets per state
   ctl_t ZR, F, D, PA, PB, EX0, EX1, EX2, EX3, IN, WR1, WR2, WRS;
   ctl_t JP, BR0, BR1, RPU, RW, RPO, JA, H;

   initial begin
      ZR  = base(4'd0);
      F   = base(4'd0);  F.mem_read1 = 1; F.ir_write = 1; F.pc_write = 1;
      D   = base(4'd1);
      PA  = base(4'd2);  PA.mem_read2 = 1; PA.vala_write = 1; PA.msp_write = 1; PA.msp_pop = 1;
      PB  = base(4'd3);  PB.mem_read2 = 1; PB.valb_write = 1; PB.msp_write = 1; PB.msp_pop = 1;
      EX0 = base(4'd4);  EX0.res_write = 1; EX0.alu_op = 2'd0;
      EX1 = base(4'd4);  EX1.res_write = 1; EX1.alu_op = 2'd1;
      EX2 = base(4'd4);  EX2.res_write = 1; EX2.alu_op = 2'd2;
      EX3 = base(4'd4);  EX3.res_write = 1; EX3.alu_op = 2'd3;
      IN  = base(4'd5);  IN.msp_write = 1;
      WR1 = base(4'd6);  WR1.mem_write2 = 1; WR1.mem_data = 3'd1;
      WR2 = base(4'd6);  WR2.mem_write2 = 1; WR2.mem_data = 3'd2;
      WRS = base(4'd6);  WRS.mem_data = 3'd1;
      JP  = base(4'd7);  JP.pc_write = 1; JP.pc_add = 1;
      BR1 = base(4'd8);  BR1.pc_write = 1; BR1.pc_add = 1;
      BR0 = base(4'd8);  BR0.pc_add = 1;
      RPU = base(4'd9);  RPU.rsp_write = 1;
      RW  = base(4'd10); RW.mem_write2 = 1; RW.mem_dst2 = 2'd1; RW.mem_data = 3'd0;
      RPO = base(4'd11); RPO.mem_read2 = 1; RPO.mem_dst2 = 2'd1; RPO.vala_write = 1;
                         RPO.rsp_write = 1; RPO.rsp_pop = 1;
      JA  = base(4'd12); JA.pc_write = 1; JA.pc_source = 1;
      H   = base(4'd13); H.halted = 1;

      // ADD: 7 cycles
      add(4'h0,0,0,F); add(4'h0,0,0,D); add(4'h0,0,0,PA); add(4'h0,0,0,PB);
      add(4'h0,0,0,EX0); add(4'h0,0,0,IN); add(4'h0,0,0,WR1);
      // OR
      add(4'h3,0,0,F); add(4'h3,0,0,D); add(4'h3,0,0,PA); add(4'h3,0,0,PB);
      add(4'h3,0,0,EX3); add(4'h3,0,0,IN); add(4'h3,0,0,WR1);
      // PUSHI with one stalled FETCH cycle
      add(4'h4,0,1,ZR); add(4'h4,0,0,F); add(4'h4,0,0,D); add(4'h4,0,0,IN); add(4'h4,0,0,WR2);
      // POP
      add(4'h5,0,0,F); add(4'h5,0,0,D); add(4'h5,0,0,PA);
      // JREL
      add(4'h6,0,0,F); add(4'h6,0,0,D); add(4'h6,0,0,JP);
      // BEQZ taken / not taken
      add(4'h7,1,0,F); add(4'h7,1,0,D); add(4'h7,1,0,PA); add(4'h7,1,0,BR1);
      add(4'h7,0,0,F); add(4'h7,0,0,D); add(4'h7,0,0,PA); add(4'h7,0,0,BR0);
      // SUB with a 3-cycle stall in WRITE
      add(4'h1,0,0,F); add(4'h1,0,0,D); add(4'h1,0,0,PA); add(4'h1,0,0,PB);
      add(4'h1,0,0,EX1); add(4'h1,0,0,IN);
      add(4'h1,0,1,WRS); add(4'h1,0,1,WRS); add(4'h1,0,1,WRS); add(4'h1,0,0,WR1);
      // CALL
      add(4'h8,0,0,F); add(4'h8,0,0,D); add(4'h8,0,0,RPU); add(4'h8,0,0,RW); add(4'h8,0,0,JP);
      // RET
      add(4'h9,0,0,F); add(4'h9,0,0,D); add(4'h9,0,0,RPO); add(4'h9,0,0,JA);

      // Reset state
      RSTn = 1'b0; Opcode = 4'h0; Zero = 1'b0; Stall = 1'b0;
      step(); step();
      chk("reset", ZR);
      RSTn = 1'b1;

      foreach (tbl[i]) begin
         Opcode = tbl[i].op;
         Zero   = tbl[i].zero;
         Stall  = tbl[i].stall;
         #1;
         chk($sformatf("row%0d", i), tbl[i].exp);
         step();
      end
      Stall = 1'b0; Zero = 1'b0;

      // Illegal opcode B halts; stall in HALT has no effect
      Opcode = 4'hB;
      #1; chk("halt_fetch", F);
      step(); chk("halt_decode", D);
      for (int i = 0; i < 20; i++) begin
         step();
         Stall = (i >= 5 && i < 9);
         #1;
         chk($sformatf("halt%0d", i), H);
      end
      Stall = 1'b0;

      // Reset pulse exits HALT
      RSTn = 1'b0;
      #1; chk("halt_rst", ZR);
      step(); chk("halt_rst_hold", ZR);
      RSTn = 1'b1;
      #1; chk("post_halt_fetch", F);

      // Asynchronous reset in the middle of EXEC
      Opcode = 4'h2;
      step(); chk("and_decode", D);
      step(); chk("and_popa", PA);
      step(); chk("and_popb", PB);
      step(); chk("and_exec", EX2);
      #2;
      RSTn = 1'b0;
      #1; chk("exec_async_rst", ZR);
      step();
      RSTn = 1'b1;
      #1; chk("rst_fetch", F);
      step(); chk("rst_decode", D);
      step(); chk("rst_popa", PA);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_stack_control_fsm
`default_nettype wire
